// File: rtl/slot_pkg.sv
// Shared types and constants for the slot bank controller.
//   state_t     : controller states (IDLE, WAIT_REELS, CREDIT)
//   tier_t      : reel grading result (LOSS, PARTIAL, JACKPOT)
//   BET_*       : stake values selectable from the bet switches
//   bet_decode  : priority decode of the bet switches, [3] highest
package slot_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_REELS = 2'd1,
    CREDIT     = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    LOSS    = 2'd0,
    PARTIAL = 2'd1,
    JACKPOT = 2'd2
  } tier_t;

  localparam int BET_W = 7;

  localparam logic [BET_W-1:0] BET_1   = 7'd1;
  localparam logic [BET_W-1:0] BET_10  = 7'd10;
  localparam logic [BET_W-1:0] BET_50  = 7'd50;
  localparam logic [BET_W-1:0] BET_100 = 7'd100;

  // No switch set decodes to a zero stake, which the controller ignores.
  function automatic logic [BET_W-1:0] bet_decode(input logic [3:0] sel);
    if (sel[3])      return BET_100;
    else if (sel[2]) return BET_50;
    else if (sel[1]) return BET_10;
    else if (sel[0]) return BET_1;
    else             return '0;
  endfunction

endpackage

// File: rtl/reel_match_grader.sv
// Combinational reel grader: finds the largest group of reels showing the
// same digit and maps it to a payout tier.
// Ports:
//   i_reels   in  NUM_REELS*DIGIT_W  packed digits, reel 0 in LSBs
//   o_max_cnt out clog2(NUM_REELS+1) size of the largest matching group
//   o_tier    out tier_t             JACKPOT (all), PARTIAL (all but one), LOSS
module reel_match_grader
  import slot_pkg::*;
#(
  parameter int NUM_REELS = 4,
  parameter int DIGIT_W   = 4
) (
  input  logic [NUM_REELS*DIGIT_W-1:0]     i_reels,
  output logic [$clog2(NUM_REELS+1)-1:0]   o_max_cnt,
  output tier_t                            o_tier
);

  localparam int CNT_W = $clog2(NUM_REELS+1);

  logic [CNT_W-1:0] w_cnt;

  // For every reel, count how many reels (itself included) carry the same
  // digit; the maximum over all reels is the largest matching group.
  always_comb begin
    o_max_cnt = '0;
    w_cnt     = '0;
    o_tier    = LOSS;
    for (int i = 0; i < NUM_REELS; i++) begin
      w_cnt = '0;
      for (int j = 0; j < NUM_REELS; j++) begin
        if (i_reels[i*DIGIT_W +: DIGIT_W] == i_reels[j*DIGIT_W +: DIGIT_W])
          w_cnt = w_cnt + CNT_W'(1);
      end
      if (w_cnt > o_max_cnt)
        o_max_cnt = w_cnt;
    end
    if (o_max_cnt == CNT_W'(NUM_REELS))
      o_tier = JACKPOT;
    else if (o_max_cnt == CNT_W'(NUM_REELS - 1))
      o_tier = PARTIAL;
  end

endmodule

// File: rtl/slot_bank_fsm.sv
// Slot machine balance keeper. Accepts one bet per spin, debits the stake
// immediately, waits for the reel generator, grades the reels and credits
// the payout clamped to MAX_BAL.
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   bet_sel       bet switches, priority [3]=100 > [2]=50 > [1]=10 > [0]=1
//   spin          one-cycle spin request (ignored while busy)
//   reels_valid   qualifies reels (only looked at in WAIT_REELS)
//   reels         packed reel digits, reel 0 in LSBs
//   balance       current balance
//   busy          state != IDLE
//   done          one-cycle pulse when the credit is applied
//   win, jackpot  valid with done
//   insufficient  one-cycle pulse when a spin is rejected for funds
// Optional build macro SLOT_BANK_STATS_EN adds spin_count / win_count
// (saturating 16-bit counters of accepted spins and winning rounds).
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | ready; a funded spin debits the stake and leaves IDLE
// WAIT_REELS | stake latched, waiting for reels_valid to grade a result
// CREDIT     | payout latched; applied to the balance on the next edge
module slot_bank_fsm
  import slot_pkg::*;
#(
  parameter int NUM_REELS    = 4,
  parameter int DIGIT_W      = 4,
  parameter int BAL_W        = 27,
  parameter int START_BAL    = 100,
  parameter int MAX_BAL      = 1000,
  parameter int JACKPOT_MULT = 2,
  parameter int PARTIAL_MULT = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [3:0]                   bet_sel,
  input  logic                         spin,
  input  logic                         reels_valid,
  input  logic [NUM_REELS*DIGIT_W-1:0] reels,
  output logic [BAL_W-1:0]             balance,
  output logic                         busy,
  output logic                         done,
  output logic                         win,
  output logic                         jackpot,
  output logic                         insufficient
`ifdef SLOT_BANK_STATS_EN
  ,
  output logic [15:0]                  spin_count,
  output logic [15:0]                  win_count
`endif
);

  // Payout and sum carry four extra bits so nothing wraps before the clamp.
  localparam int PAY_W = BAL_W + 4;
  localparam int CNT_W = $clog2(NUM_REELS + 1);

  state_t              r_state, w_state_nxt;
  logic [BAL_W-1:0]    r_balance, w_balance_nxt;
  logic [BET_W-1:0]    r_bet, w_bet_nxt;
  logic [PAY_W-1:0]    r_payout, w_payout_nxt;
  logic                r_all_match, w_all_match_nxt;
  logic                r_done, w_done_nxt;
  logic                r_win, w_win_nxt;
  logic                r_jackpot, w_jackpot_nxt;
  logic                r_insufficient, w_insufficient_nxt;
  logic                w_spin_accept;

  logic [BET_W-1:0]    w_bet_req;
  logic [CNT_W-1:0]    w_max_cnt;
  tier_t               w_tier;
  logic [PAY_W-1:0]    w_payout_graded;
  logic [PAY_W-1:0]    w_sum;
  logic [BAL_W-1:0]    w_credit_bal;

  reel_match_grader #(
    .NUM_REELS (NUM_REELS),
    .DIGIT_W   (DIGIT_W)
  ) u_grader (
    .i_reels   (reels),
    .o_max_cnt (w_max_cnt),
    .o_tier    (w_tier)
  );

  assign w_bet_req = bet_decode(bet_sel);

  always_comb begin
    w_payout_graded = '0;
    case (w_tier)
      JACKPOT: w_payout_graded = PAY_W'(r_bet) * PAY_W'(JACKPOT_MULT);
      PARTIAL: w_payout_graded = PAY_W'(r_bet) * PAY_W'(PARTIAL_MULT);
      default: w_payout_graded = '0;
    endcase
  end

  assign w_sum        = PAY_W'(r_balance) + r_payout;
  assign w_credit_bal = (w_sum > PAY_W'(MAX_BAL)) ? BAL_W'(MAX_BAL) : w_sum[BAL_W-1:0];

  always_comb begin
    w_state_nxt        = r_state;
    w_balance_nxt      = r_balance;
    w_bet_nxt          = r_bet;
    w_payout_nxt       = r_payout;
    w_all_match_nxt    = r_all_match;
    w_done_nxt         = 1'b0;
    w_win_nxt          = 1'b0;
    w_jackpot_nxt      = 1'b0;
    w_insufficient_nxt = 1'b0;
    w_spin_accept      = 1'b0;
    case (r_state)
      IDLE: begin
        if (spin && (w_bet_req != '0)) begin
          if (BAL_W'(w_bet_req) > r_balance) begin
            w_insufficient_nxt = 1'b1;
          end else begin
            w_spin_accept = 1'b1;
            w_bet_nxt     = w_bet_req;
            w_balance_nxt = r_balance - BAL_W'(w_bet_req);
            w_state_nxt   = WAIT_REELS;
          end
        end
      end
      WAIT_REELS: begin
        if (reels_valid) begin
          w_payout_nxt    = w_payout_graded;
          w_all_match_nxt = (w_max_cnt == CNT_W'(NUM_REELS));
          w_state_nxt     = CREDIT;
        end
      end
      CREDIT: begin
        w_balance_nxt = w_credit_bal;
        w_done_nxt    = 1'b1;
        w_win_nxt     = (r_payout != '0);
        w_jackpot_nxt = r_all_match;
        w_state_nxt   = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_balance      <= BAL_W'(START_BAL);
      r_bet          <= '0;
      r_payout       <= '0;
      r_all_match    <= 1'b0;
      r_done         <= 1'b0;
      r_win          <= 1'b0;
      r_jackpot      <= 1'b0;
      r_insufficient <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_balance      <= w_balance_nxt;
      r_bet          <= w_bet_nxt;
      r_payout       <= w_payout_nxt;
      r_all_match    <= w_all_match_nxt;
      r_done         <= w_done_nxt;
      r_win          <= w_win_nxt;
      r_jackpot      <= w_jackpot_nxt;
      r_insufficient <= w_insufficient_nxt;
    end
  end

  assign balance      = r_balance;
  assign busy         = (r_state != IDLE);
  assign done         = r_done;
  assign win          = r_win;
  assign jackpot      = r_jackpot;
  assign insufficient = r_insufficient;

`ifdef SLOT_BANK_STATS_EN
  logic [15:0] r_spin_count;
  logic [15:0] r_win_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_spin_count <= '0;
      r_win_count  <= '0;
    end else begin
      if (w_spin_accept && (r_spin_count != 16'hFFFF))
        r_spin_count <= r_spin_count + 16'd1;
      if (w_win_nxt && (r_win_count != 16'hFFFF))
        r_win_count <= r_win_count + 16'd1;
    end
  end

  assign spin_count = r_spin_count;
  assign win_count  = r_win_count;
`endif

endmodule

// File: tb/tb_slot_bank_fsm.sv
// Bench for slot_bank_fsm: directed scenarios plus randomized rounds checked
// against a behavioural balance model. A second instance starts near the
// ceiling to exercise the credit clamp.
module tb_slot_bank_fsm;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, spin, reels_valid;
  logic [3:0]  bet_sel;
  logic [15:0] reels;
  logic [26:0] balance;
  logic        busy, done, win, jackpot, insufficient;

  logic        b_rst, b_spin, b_reels_valid;
  logic [3:0]  b_bet_sel;
  logic [15:0] b_reels;
  logic [26:0] b_balance;
  logic        b_busy, b_done, b_win, b_jackpot, b_insufficient;

`ifdef SLOT_BANK_STATS_EN
  logic [15:0] spin_count, win_count, b_spin_count, b_win_count;
`endif

  slot_bank_fsm dut (
    .clk(clk), .rst(rst), .bet_sel(bet_sel), .spin(spin),
    .reels_valid(reels_valid), .reels(reels), .balance(balance),
    .busy(busy), .done(done), .win(win), .jackpot(jackpot),
    .insufficient(insufficient)
`ifdef SLOT_BANK_STATS_EN
    , .spin_count(spin_count), .win_count(win_count)
`endif
  );

  slot_bank_fsm #(.START_BAL(950)) dut_hi (
    .clk(clk), .rst(b_rst), .bet_sel(b_bet_sel), .spin(b_spin),
    .reels_valid(b_reels_valid), .reels(b_reels), .balance(b_balance),
    .busy(b_busy), .done(b_done), .win(b_win), .jackpot(b_jackpot),
    .insufficient(b_insufficient)
`ifdef SLOT_BANK_STATS_EN
    , .spin_count(b_spin_count), .win_count(b_win_count)
`endif
  );

  int errors = 0;
  int checks = 0;
  int m_bal  = 100;

  task automatic chkv(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference rules, written directly from the game description.
  function automatic int f_bet(input logic [3:0] s);
    if (s[3]) return 100;
    if (s[2]) return 50;
    if (s[1]) return 10;
    if (s[0]) return 1;
    return 0;
  endfunction

  function automatic int f_maxmatch(input logic [15:0] r);
    int hist[16];
    int best;
    for (int k = 0; k < 16; k++) hist[k] = 0;
    for (int i = 0; i < 4; i++) hist[r[i*4 +: 4]]++;
    best = 0;
    for (int k = 0; k < 16; k++) if (hist[k] > best) best = hist[k];
    return best;
  endfunction

  function automatic int f_payout(input int bet, input int m);
    if (m == 4) return bet * 2;
    if (m == 3) return bet * 1;
    return 0;
  endfunction

  function automatic logic [15:0] f_rand_reels();
    logic [3:0]  base;
    logic [15:0] r;
    base = 4'($urandom);
    for (int i = 0; i < 4; i++)
      r[i*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : base;
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_bal = 100;
    chkv("reset_balance", int'(balance), 100);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_done", done, 1'b0);
    chk1("reset_win", win, 1'b0);
    chk1("reset_jackpot", jackpot, 1'b0);
    chk1("reset_insufficient", insufficient, 1'b0);
  endtask

  // One complete round on the main instance, expectations from the model.
  task automatic spin_round(input logic [3:0] sel, input logic [15:0] r, input int delay);
    int bet, pay, m;
    bet = f_bet(sel);
    bet_sel = sel;
    spin = 1'b1;
    tick();
    spin = 1'b0;
    if (bet == 0) begin
      chk1("zero_bet_busy", busy, 1'b0);
      chk1("zero_bet_insuf", insufficient, 1'b0);
      chkv("zero_bet_balance", int'(balance), m_bal);
    end else if (bet > m_bal) begin
      chk1("insuf_pulse", insufficient, 1'b1);
      chk1("insuf_busy", busy, 1'b0);
      chkv("insuf_balance", int'(balance), m_bal);
      tick();
      chk1("insuf_pulse_end", insufficient, 1'b0);
      chkv("insuf_balance_hold", int'(balance), m_bal);
    end else begin
      m_bal = m_bal - bet;
      chkv("debit_balance", int'(balance), m_bal);
      chk1("debit_busy", busy, 1'b1);
      chk1("debit_done", done, 1'b0);
      bet_sel = 4'($urandom);
      for (int d = 0; d < delay; d++) begin
        spin  = 1'($urandom_range(0, 1));
        reels = 16'($urandom);
        tick();
        chk1("wait_busy", busy, 1'b1);
        chk1("wait_done", done, 1'b0);
        chkv("wait_balance", int'(balance), m_bal);
      end
      spin = 1'b0;
      reels = r;
      reels_valid = 1'b1;
      tick();
      reels_valid = 1'($urandom_range(0, 1));
      reels = 16'($urandom);
      chk1("credit_busy", busy, 1'b1);
      chk1("credit_done", done, 1'b0);
      chkv("credit_balance_pre", int'(balance), m_bal);
      tick();
      m   = f_maxmatch(r);
      pay = f_payout(bet, m);
      m_bal = (m_bal + pay > 1000) ? 1000 : m_bal + pay;
      chk1("done_pulse", done, 1'b1);
      chk1("done_win", win, pay > 0);
      chk1("done_jackpot", jackpot, m == 4);
      chkv("done_balance", int'(balance), m_bal);
      chk1("done_busy", busy, 1'b0);
      tick();
      reels_valid = 1'b0;
      chk1("done_end", done, 1'b0);
      chkv("after_balance", int'(balance), m_bal);
    end
  endtask

  initial begin
    rst = 1'b1; spin = 1'b0; reels_valid = 1'b0; bet_sel = '0; reels = '0;
    b_rst = 1'b1; b_spin = 1'b0; b_reels_valid = 1'b0; b_bet_sel = '0; b_reels = '0;
    @(negedge clk);
    do_reset();
    tick();
    chkv("idle_balance", int'(balance), 100);
    chk1("idle_busy", busy, 1'b0);

    // Loss, jackpot and partial rounds from a fresh balance.
    spin_round(4'b0010, 16'h4321, 0);
    do_reset();
    spin_round(4'b0110, 16'h7777, 0);
    do_reset();
    spin_round(4'b0010, 16'h3393, 1);

    // Drain to 40, then a 50 stake is refused; a zero stake is ignored.
    do_reset();
    spin_round(4'b0100, 16'h1234, 0);
    spin_round(4'b0010, 16'h5678, 2);
    spin_round(4'b0100, 16'h9999, 0);
    spin_round(4'b0000, 16'h9999, 0);
    chkv("drained_balance", int'(balance), 40);

    // Reset while waiting for the reels discards the stake.
    do_reset();
    bet_sel = 4'b0010; spin = 1'b1; tick(); spin = 1'b0;
    chkv("mid_debit", int'(balance), 90);
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chkv("mid_rst_balance", int'(balance), 100);
    chk1("mid_rst_busy", busy, 1'b0);
    reels = 16'h7777; reels_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk1("mid_rst_no_done", done, 1'b0);
      chkv("mid_rst_hold", int'(balance), 100);
    end
    reels_valid = 1'b0;

    // Reset while in CREDIT suppresses the credit and the done pulse.
    bet_sel = 4'b0100; spin = 1'b1; tick(); spin = 1'b0;
    reels_valid = 1'b1; tick(); reels_valid = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    chk1("credit_rst_done", done, 1'b0);
    chkv("credit_rst_balance", int'(balance), 100);
    m_bal = 100;

    // Ceiling behaviour on the instance that starts at 950.
    b_rst = 1'b0;
    chkv("hi_reset", int'(b_balance), 950);
    b_bet_sel = 4'b1000; b_spin = 1'b1; tick(); b_spin = 1'b0;
    chkv("hi_debit", int'(b_balance), 850);
    b_reels = 16'h5555; b_reels_valid = 1'b1; tick(); b_reels_valid = 1'b0; tick();
    chk1("hi_done", b_done, 1'b1);
    chk1("hi_jackpot", b_jackpot, 1'b1);
    chkv("hi_clamp", int'(b_balance), 1000);
    tick();
    b_bet_sel = 4'b0001; b_spin = 1'b1; tick(); b_spin = 1'b0;
    chkv("hi_debit1", int'(b_balance), 999);
    b_reels_valid = 1'b1; tick(); b_reels_valid = 1'b0; tick();
    chkv("hi_stay_max", int'(b_balance), 1000);
    tick();
    b_bet_sel = 4'b1000; b_reels = 16'h5155; b_spin = 1'b1; tick(); b_spin = 1'b0;
    b_reels_valid = 1'b1; tick(); b_reels_valid = 1'b0; tick();
    chk1("hi_partial_win", b_win, 1'b1);
    chk1("hi_partial_jp", b_jackpot, 1'b0);
    chkv("hi_partial_bal", int'(b_balance), 1000);

    // Randomized rounds against the model.
    do_reset();
    for (int n = 0; n < 60; n++) begin
      if (m_bal < 5) do_reset();
      spin_round(4'($urandom), f_rand_reels(), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/slot_bank_fsm.md
Name: slot_bank_fsm

Overview:
- Parametrised successor to the slot-machine balance keeper.
- Takes one bet per spin through an explicit spin/result handshake with the reel generator.
- Debits the stake up front, grades the reel result into jackpot, partial or loss tiers, and credits the payout with saturation.
- Sits between the switch/button inputs, the reel random generator and the balance display driver.

Parameters:
- NUM_REELS, 4, number of reel digits compared (>=3)
- DIGIT_W, 4, width of each reel digit
- BAL_W, 27, balance register width
- START_BAL, 100, balance after reset (must be <= MAX_BAL)
- MAX_BAL, 1000, saturation ceiling for credits
- JACKPOT_MULT, 2, payout = bet*JACKPOT_MULT when all reels match
- PARTIAL_MULT, 1, payout = bet*PARTIAL_MULT when exactly NUM_REELS-1 reels share a value

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- bet_sel  in  4  bet switches; priority [3]=100 > [2]=50 > [1]=10 > [0]=1; none set = 0
- spin  in  1  one-cycle spin request
- reels_valid  in  1  reel result valid, qualifies reels
- reels  in  NUM_REELS*DIGIT_W  packed reel digits, reel 0 in LSBs
- balance  out  BAL_W  current balance
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when the credit is applied
- win  out  1  valid with done; payout > 0
- jackpot  out  1  valid with done; all reels matched
- insufficient  out  1  one-cycle pulse when a spin is rejected for funds

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset values:
  - balance = START_BAL; state = IDLE.
  - busy, done, win, jackpot, insufficient = 0; latched bet = 0.
- States: IDLE, WAIT_REELS, CREDIT.
- IDLE, spin=1 at edge N:
  - Bet value is priority-decoded from bet_sel in the same cycle.
  - bet=0: spin is ignored and the state stays IDLE.
  - bet > balance: insufficient=1 for cycle N+1; balance is unchanged; the state stays IDLE.
  - Otherwise: the bet is latched, balance = balance - bet at N+1, and the state moves to WAIT_REELS at N+1. Balance never underflows.
- WAIT_REELS:
  - Waits indefinitely for reels_valid.
  - At the edge where reels_valid=1, the match tier is graded, payout is computed and latched, and the state moves to CREDIT.
- Grading: m = largest count of reels sharing one value.
  - m == NUM_REELS: jackpot tier.
  - m == NUM_REELS-1: partial tier.
  - Otherwise: loss, payout 0.
- CREDIT (one cycle):
  - balance = min(balance + payout, MAX_BAL).
  - done=1 the following cycle, with win and jackpot valid alongside it.
  - The state returns to IDLE.
- Arithmetic:
  - Payout and sum are computed at BAL_W+4 bits before clamping, so there is no wrap.
  - A balance equal to MAX_BAL stays at MAX_BAL.
- spin while busy is ignored (not queued). reels_valid outside WAIT_REELS is ignored.
- bet_sel changes after a spin is accepted do not affect the latched bet.
- rst in any state, including mid-spin, wins over all other inputs:
  - Next cycle: IDLE, balance = START_BAL, all pulses 0.
  - The stake in flight is discarded.
- Minimum spin-to-done latency with reels_valid held high is 3 cycles.

Optional Feature:
- Macro: SLOT_BANK_STATS_EN.
- Defined:
  - Adds outputs spin_count[15:0] (accepted spins) and win_count[15:0] (done with win=1).
  - Both saturate at 16'hFFFF and clear on rst.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package slot_pkg:
  - state enum (IDLE, WAIT_REELS, CREDIT)
  - bet constants BET_1/10/50/100
  - tier enum (LOSS, PARTIAL, JACKPOT)
- Sub-module reel_match_grader (combinational):
  - Inputs: reels.
  - Outputs: max match count and tier.
  - Reusable by the display/score logic.

Test Plan:
- Reset, no activity -> balance=100, busy=0, all pulses 0.
- bet_sel=4'b0010, spin, reels=1,2,3,4 -> balance 90 one cycle after spin; done with win=0; final balance 90.
- bet_sel=4'b0110 (50 wins), spin, reels=7,7,7,7 -> balance 50 then 150; done, win=1, jackpot=1.
- bet_sel=4'b0010, spin, reels=3,3,9,3 -> balance 90 then 100; win=1, jackpot=0.
- START_BAL=950: bet 100, reels=5,5,5,5 -> 850 then clamps to 1000. From 40, bet 50 -> insufficient pulse, balance stays 40, busy=0.
- Spin accepted, rst asserted in WAIT_REELS -> next cycle balance=100, IDLE; a later reels_valid produces no done.
